// File: rtl/volume_multi.sv
// -----------------------------------------------------------------------------
// volume_multi
//
// Multi-channel volume control. Each channel owns a requested attenuation
// (target) and the attenuation actually applied to samples (applied), both
// expressed as an arithmetic right-shift count. Louder/quieter buttons move
// the target one step per rising edge. The applied value ramps one step
// toward the target per accepted sample, so level changes are spread over
// the sample stream instead of producing a single jump.
//
// Samples flow through a single output register with a valid/ready
// handshake: one cycle of latency, and one beat per cycle when the
// downstream stage keeps ready_i high.
//
// Ports
//   clk_i     in   1                           sole clock, rising edge
//   reset_i   in   1                           synchronous, active-high reset
//   sound_i   in   channels_p*width_p          packed signed samples,
//                                              channel c at [c*width_p +: width_p]
//   valid_i   in   1                           sound_i beat valid
//   ready_o   out  1                           block can accept a beat
//   up_i      in   channels_p                  per-channel louder request
//   down_i    in   channels_p                  per-channel quieter request
//   mute_i    in   channels_p                  per-channel mute level
//   sound_o   out  channels_p*width_p          attenuated samples, same packing
//   valid_o   out  1                           sound_o beat valid
//   ready_i   in   1                           downstream accepts the beat
//   atten_o   out  channels_p*$clog2(width_p)  per-channel applied attenuation
// -----------------------------------------------------------------------------
module volume_multi #(
  parameter int width_p       = 24,
  parameter int channels_p    = 2,
  parameter int min_atten_p   = 1,
  parameter int max_atten_p   = 7,
  parameter int reset_atten_p = 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [channels_p*width_p-1:0]         sound_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic [channels_p-1:0]                 up_i,
  input  logic [channels_p-1:0]                 down_i,
  input  logic [channels_p-1:0]                 mute_i,
  output logic [channels_p*width_p-1:0]         sound_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [channels_p*$clog2(width_p)-1:0] atten_o
);

  localparam int AW = $clog2(width_p);

  localparam logic [AW-1:0] MIN_A   = AW'(min_atten_p);
  localparam logic [AW-1:0] MAX_A   = AW'(max_atten_p);
  localparam logic [AW-1:0] RESET_A = AW'(reset_atten_p);

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Sign-preserving attenuation: arithmetic shift rounds toward minus infinity.
  function automatic logic signed [width_p-1:0] atten_shift(
    input logic signed [width_p-1:0] sample,
    input logic        [AW-1:0]      shift
  );
    return sample >>> shift;
  endfunction

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] a);
    return (a >= MAX_A) ? MAX_A : a + AW'(1);
  endfunction

  function automatic logic [AW-1:0] sat_dec(input logic [AW-1:0] a);
    return (a <= MIN_A) ? MIN_A : a - AW'(1);
  endfunction

  // Simultaneous up/down edges cancel out.
  function automatic logic [AW-1:0] next_target(
    input logic [AW-1:0] t,
    input logic          up_rise,
    input logic          dn_rise
  );
    logic [AW-1:0] n;
    n = t;
    if (up_rise && !dn_rise)      n = sat_dec(t);
    else if (dn_rise && !up_rise) n = sat_inc(t);
    return n;
  endfunction

  // One step of the ramp; target is always in range so no saturation needed.
  function automatic logic [AW-1:0] step_toward(
    input logic [AW-1:0] cur,
    input logic [AW-1:0] tgt
  );
    logic [AW-1:0] n;
    n = cur;
    if (cur < tgt)      n = cur + AW'(1);
    else if (cur > tgt) n = cur - AW'(1);
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: input handshake
  // ---------------------------------------------------------------------------
  logic r_vld_p1;
  logic w_accept_p0;

  // The output register frees up either when empty or when draining this cycle.
  assign ready_o     = ~r_vld_p1 | ready_i;
  assign w_accept_p0 = valid_i & ready_o;

  // ---------------------------------------------------------------------------
  // Stage p1: output register valid
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept_p0) begin
      r_vld_p1 <= 1'b1;
    end else if (ready_i) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign valid_o = r_vld_p1;

  // ---------------------------------------------------------------------------
  // Per-channel volume state and sample datapath
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < channels_p; c++) begin : g_ch
    logic                      r_up_d;
    logic                      r_dn_d;
    logic [AW-1:0]             r_target;
    logic [AW-1:0]             r_applied;
    logic signed [width_p-1:0] r_sound_p1;

    logic                      w_up_rise;
    logic                      w_dn_rise;
    logic signed [width_p-1:0] w_sample_p0;

    assign w_sample_p0 = sound_i[c*width_p +: width_p];
    assign w_up_rise   = up_i[c]   & ~r_up_d;
    assign w_dn_rise   = down_i[c] & ~r_dn_d;

    // Button edge history and target attenuation run every cycle,
    // independent of sample flow.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_up_d   <= 1'b0;
        r_dn_d   <= 1'b0;
        r_target <= RESET_A;
      end else begin
        r_up_d   <= up_i[c];
        r_dn_d   <= down_i[c];
        r_target <= next_target(r_target, w_up_rise, w_dn_rise);
      end
    end

    // Stage p0 -> p1: the beat is shifted by the applied value before it
    // steps, so each beat reflects the attenuation in force when it arrived.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_applied  <= RESET_A;
        r_sound_p1 <= '0;
      end else if (w_accept_p0) begin
        r_applied  <= step_toward(r_applied, r_target);
        r_sound_p1 <= mute_i[c] ? '0 : atten_shift(w_sample_p0, r_applied);
      end
    end

    assign sound_o[c*width_p +: width_p] = r_sound_p1;
    assign atten_o[c*AW +: AW]           = r_applied;
  end

endmodule

// File: tb/tb_volume_multi.sv
module tb_volume_multi;

  localparam int W     = 24;
  localparam int C     = 2;
  localparam int AW    = $clog2(W);
  localparam int MIN_A = 1;
  localparam int MAX_A = 7;
  localparam int RST_A = 1;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [C*W-1:0]   sound_i;
  logic             valid_i;
  logic             ready_o;
  logic [C-1:0]     up_i;
  logic [C-1:0]     down_i;
  logic [C-1:0]     mute_i;
  logic [C*W-1:0]   sound_o;
  logic             valid_o;
  logic             ready_i;
  logic [C*AW-1:0]  atten_o;

  always #5 clk_i = ~clk_i;

  volume_multi dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sound_i (sound_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .up_i    (up_i),
    .down_i  (down_i),
    .mute_i  (mute_i),
    .sound_o (sound_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .atten_o (atten_o)
  );

  typedef struct {
    logic [C*W-1:0] snd;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Reference model state (value that will hold after the next clock edge)
  int  m_tgt[C];
  int  m_app[C];
  bit  m_up_prev[C];
  bit  m_dn_prev[C];
  bit  m_vo;
  // Model state currently visible on the DUT outputs
  int  app_cur[C];
  bit  vo_cur;

  bit             mon_en = 1'b0;
  bit             prev_hold = 1'b0;
  logic [C*W-1:0] prev_snd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Attenuation as floor division by 2^sh on the signed sample value.
  function automatic logic [W-1:0] ref_atten(input logic [W-1:0] s, input int sh);
    longint v, d, q;
    v = longint'($signed(s));
    d = longint'(1) << sh;
    q = v / d;
    if (v < 0 && q * d != v) q = q - 1;
    return q[W-1:0];
  endfunction

  // Advance the model by one clock using the inputs currently driven,
  // then let the DUT take the same clock edge.
  task automatic step();
    bit   acc;
    exp_t e;
    vo_cur = m_vo;
    for (int c = 0; c < C; c++) app_cur[c] = m_app[c];
    if (reset_i) begin
      for (int c = 0; c < C; c++) begin
        m_tgt[c]     = RST_A;
        m_app[c]     = RST_A;
        m_up_prev[c] = 1'b0;
        m_dn_prev[c] = 1'b0;
      end
      m_vo = 1'b0;
      sbq.delete();
    end else begin
      acc = valid_i && (!m_vo || ready_i);
      if (acc) begin
        for (int c = 0; c < C; c++) begin
          e.snd[c*W +: W] = mute_i[c] ? '0 : ref_atten(sound_i[c*W +: W], m_app[c]);
          if (m_app[c] < m_tgt[c])      m_app[c] = m_app[c] + 1;
          else if (m_app[c] > m_tgt[c]) m_app[c] = m_app[c] - 1;
        end
        sbq.push_back(e);
      end
      for (int c = 0; c < C; c++) begin
        bit ur, dr;
        ur = up_i[c]   && !m_up_prev[c];
        dr = down_i[c] && !m_dn_prev[c];
        if (ur && !dr)      m_tgt[c] = (m_tgt[c] > MIN_A) ? m_tgt[c] - 1 : MIN_A;
        else if (dr && !ur) m_tgt[c] = (m_tgt[c] < MAX_A) ? m_tgt[c] + 1 : MAX_A;
        m_up_prev[c] = up_i[c];
        m_dn_prev[c] = down_i[c];
      end
      m_vo = acc ? 1'b1 : (ready_i ? 1'b0 : m_vo);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    up_i    = '0;
    down_i  = '0;
    mute_i  = '0;
    ready_i = 1'b1;
  endtask

  task automatic pulse_down(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      down_i[ch] = 1'b1; step();
      down_i[ch] = 1'b0; step();
    end
  endtask

  task automatic pulse_up(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      up_i[ch] = 1'b1; step();
      up_i[ch] = 1'b0; step();
    end
  endtask

  task automatic beat(input logic [W-1:0] s0, input logic [W-1:0] s1);
    valid_i = 1'b1;
    sound_i = {s1, s0};
    step();
    valid_i = 1'b0;
  endtask

  // Monitor: mid-cycle checks of handshake, attenuation and scoreboard data.
  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("valid_o", 64'(valid_o), 64'(vo_cur));
      chk("ready_o", 64'(ready_o), 64'(!vo_cur || ready_i));
      for (int c = 0; c < C; c++)
        chk("atten_o", 64'(atten_o[c*AW +: AW]), 64'(app_cur[c]));
      if (prev_hold && !reset_i) chk("hold_sound", 64'(sound_o), 64'(prev_snd));
      prev_hold = valid_o && !ready_i && !reset_i;
      prev_snd  = sound_o;
      if (!reset_i && valid_o && ready_i) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got beat %0h expected none", sound_o);
        end else begin
          mon_e = sbq.pop_front();
          chk("sound_o", 64'(sound_o), 64'(mon_e.snd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < C; c++) begin
      m_tgt[c] = RST_A; m_app[c] = RST_A; app_cur[c] = RST_A;
      m_up_prev[c] = 1'b0; m_dn_prev[c] = 1'b0;
    end
    m_vo = 1'b0; vo_cur = 1'b0;
    idle();
    sound_i = '0;
    reset_i = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_atten", 64'(atten_o), 64'({5'd1, 5'd1}));
    chk("rst_sound", 64'(sound_o), 64'd0);
    reset_i = 1'b0;

    // Basic shift by the reset attenuation
    beat(24'h000100, 24'h000200);
    chk("basic_ch0", 64'(sound_o[W-1:0]), 64'h000080);
    chk("basic_att", 64'(atten_o[AW-1:0]), 64'd1);
    step();

    // Negative sample at attenuation 3
    pulse_down(0, 2);
    beat(24'h123456, 24'h000010);
    beat(24'h654321, 24'h000010);
    chk("ramp_to3", 64'(atten_o[AW-1:0]), 64'd3);
    beat(24'hFFFF00, 24'h000000);
    chk("sign_ch0", 64'(sound_o[W-1:0]), 64'hFFFFE0);
    step();

    reset_i = 1'b1; step(); reset_i = 1'b0;

    // Held down counts once, later pulses saturate at the maximum
    down_i[0] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    down_i[0] = 1'b0;
    step();
    pulse_down(0, 6);
    valid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sound_i = (C*W)'({$urandom(), $urandom()});
      step();
      chk("ramp_ch0", 64'(atten_o[AW-1:0]), 64'(k + 2));
      chk("ramp_ch1", 64'(atten_o[2*AW-1:AW]), 64'd1);
    end
    valid_i = 1'b0;
    step();

    // Simultaneous up/down cancel; up at the minimum stays put
    up_i[0] = 1'b1; down_i[0] = 1'b1; step();
    up_i[0] = 1'b0; down_i[0] = 1'b0; step();
    pulse_up(1, 1);
    beat(24'h7FFFFF, 24'h800000);
    chk("cancel_ch0", 64'(atten_o[AW-1:0]), 64'd7);
    chk("minsat_ch1", 64'(atten_o[2*AW-1:AW]), 64'd1);
    step();

    // Backpressure while ramping down
    pulse_up(0, 3);
    ready_i = 1'b0;
    beat(24'h0ABCDE, 24'hF00000);
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sound_i = (C*W)'({$urandom(), $urandom()});
      step();
      chk("stall_ready", 64'(ready_o), 64'd0);
      chk("stall_atten", 64'(atten_o[AW-1:0]), 64'd6);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sound_i = (C*W)'({$urandom(), $urandom()});
      step();
    end
    valid_i = 1'b0;
    step();

    // Mute on channel 1 only (channel 0 now at 4)
    mute_i = 2'b10;
    beat(24'h001000, 24'h3FFFFF);
    chk("mute_ch1", 64'(sound_o[2*W-1:W]), 64'd0);
    chk("mute_ch0", 64'(sound_o[W-1:0]), 64'h000100);
    mute_i = '0;
    step();

    // Reset while ramping with a beat parked in the output register
    pulse_down(0, 3);
    valid_i = 1'b1;
    sound_i = (C*W)'({$urandom(), $urandom()}); step();
    sound_i = (C*W)'({$urandom(), $urandom()}); step();
    valid_i = 1'b0;
    ready_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    chk("rst_mid_valid", 64'(valid_o), 64'd0);
    chk("rst_mid_atten", 64'(atten_o), 64'({5'd1, 5'd1}));
    reset_i = 1'b0;
    ready_i = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      up_i    = C'($urandom() & $urandom() & $urandom());
      down_i  = C'($urandom() & $urandom() & $urandom());
      mute_i  = C'($urandom() & $urandom() & $urandom());
      reset_i = ($urandom_range(0, 149) == 0);
      sound_i = (C*W)'({$urandom(), $urandom()});
      step();
    end

    reset_i = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("sb_drain", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
